turn_sequencer: RTL and testbench

Game-flow controller for Keyboard Battleship. It drives the 3-bit game `state` bus that the fire-permission logic and the display decode. It sequences ship placement for both players, then alternates firing turns. It counts hits per player, forces a turn change when a player idles too long, and latches the winner.

---
 rtl/turn_sequencer.sv | 126 ++++++++++++
 tb/tb_turn_sequencer.sv | 128 ++++++++++++
 2 files changed

// File: rtl/turn_sequencer.sv
// turn_sequencer: game-flow controller for Keyboard Battleship.
// Sequences ship placement for both players, alternates firing turns,
// counts hits, forfeits idle turns and latches the winner.
module turn_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd1_000_000_000,
  parameter int unsigned HITS_TO_WIN    = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       p1_ready,
  input  logic       p2_ready,
  input  logic       fire,
  input  logic       hit,
  output logic [2:0] state,
  output logic [4:0] p1_hits,
  output logic [4:0] p2_hits,
  output logic       turn_timeout,
  output logic       game_over
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    P1_PLACE = 3'd1,
    P2_PLACE = 3'd2,
    P1_TURN  = 3'd3,
    P2_TURN  = 3'd4,
    P1_WIN   = 3'd5,
    P2_WIN   = 3'd6,
    UNUSED   = 3'd7
  } state_t;

  localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]  WIN_LAST = 5'(HITS_TO_WIN - 1);

  state_t      state_q, state_d;
  logic [4:0]  p1_d, p2_d;
  logic [31:0] idle_q, idle_d;
  logic        go_d;
  logic        in_turn;
  logic        timeout_hit;

  assign state = state_q;

  // Next-state, hit counters, idle counter and forfeit detection.
  always_comb begin
    state_d     = state_q;
    p1_d        = p1_hits;
    p2_d        = p2_hits;
    in_turn     = (state_q == P1_TURN) || (state_q == P2_TURN);
    // A resolved shot in the last idle cycle takes priority over forfeit.
    timeout_hit = in_turn && !fire && (idle_q == TO_LAST);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = P1_PLACE;
          p1_d    = '0;
          p2_d    = '0;
        end
      end
      P1_PLACE: begin
        if (p1_ready) state_d = P2_PLACE;
      end
      P2_PLACE: begin
        if (p2_ready) state_d = P1_TURN;
      end
      P1_TURN: begin
        if (fire) begin
          if (hit) p1_d = p1_hits + 5'd1;
          if (hit && (p1_hits == WIN_LAST)) state_d = P1_WIN;
          else                              state_d = P2_TURN;
        end else if (timeout_hit) begin
          state_d = P2_TURN;
        end
      end
      P2_TURN: begin
        if (fire) begin
          if (hit) p2_d = p2_hits + 5'd1;
          if (hit && (p2_hits == WIN_LAST)) state_d = P2_WIN;
          else                              state_d = P1_TURN;
        end else if (timeout_hit) begin
          state_d = P1_TURN;
        end
      end
      P1_WIN, P2_WIN: begin
        if (start) begin
          state_d = P1_PLACE;
          p1_d    = '0;
          p2_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Counter restarts on any turn entry and stays at zero outside turns.
    if (((state_d == P1_TURN) || (state_d == P2_TURN)) && (state_d == state_q))
      idle_d = idle_q + 32'd1;
    else
      idle_d = '0;

    go_d = (state_d == P1_WIN) || (state_d == P2_WIN);

    // Forfeit pulse is qualified by the same-cycle fire, so it is decoded
    // from registered state rather than registered itself.
    turn_timeout = timeout_hit;
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      p1_hits   <= '0;
      p2_hits   <= '0;
      idle_q    <= '0;
      game_over <= 1'b0;
    end else begin
      state_q   <= state_d;
      p1_hits   <= p1_d;
      p2_hits   <= p2_d;
      idle_q    <= idle_d;
      game_over <= go_d;
    end
  end

endmodule

// File: tb/tb_turn_sequencer.sv
// tb_turn_sequencer: directed scoreboard bench for turn_sequencer
// with TIMEOUT_CYCLES=8 and HITS_TO_WIN=3.
module tb_turn_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, p1_ready, p2_ready, fire, hit;
  logic [2:0] state;
  logic [4:0] p1_hits, p2_hits;
  logic       turn_timeout, game_over;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    string      tag;
    logic [2:0] st;
    logic [4:0] h1;
    logic [4:0] h2;
    logic       go;
  } exp_t;

  exp_t sb[$];

  turn_sequencer #(.TIMEOUT_CYCLES(8), .HITS_TO_WIN(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .p1_ready     (p1_ready),
    .p2_ready     (p2_ready),
    .fire         (fire),
    .hit          (hit),
    .state        (state),
    .p1_hits      (p1_hits),
    .p2_hits      (p2_hits),
    .turn_timeout (turn_timeout),
    .game_over    (game_over)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check the in-cycle forfeit pulse
  // (eto < 0 skips it), queue the post-edge expectation, then pop and
  // compare it once the edge has produced the registered outputs.
  task automatic step(input string tag, input logic s, input logic r1, input logic r2,
                      input logic f, input logic h, input logic rst,
                      input logic [2:0] es, input logic [4:0] e1, input logic [4:0] e2,
                      input logic ego, input int eto);
    exp_t e;
    exp_t got;
    start = s; p1_ready = r1; p2_ready = r2; fire = f; hit = h; reset = rst;
    #3;
    if (eto >= 0) chk({tag, ".turn_timeout"}, 32'(turn_timeout), 32'(eto));
    e.tag = tag; e.st = es; e.h1 = e1; e.h2 = e2; e.go = ego;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk({got.tag, ".state"},     32'(state),     32'(got.st));
    chk({got.tag, ".p1_hits"},   32'(p1_hits),   32'(got.h1));
    chk({got.tag, ".p2_hits"},   32'(p2_hits),   32'(got.h2));
    chk({got.tag, ".game_over"}, 32'(game_over), 32'(got.go));
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; p1_ready = 1'b0; p2_ready = 1'b0; fire = 1'b0; hit = 1'b0;
    @(posedge clk);
    #1;
    //   tag            st r1 r2 f  h  rst  state p1 p2 go  to
    step("reset",       0, 0, 0, 0, 0, 0,   0,    0, 0, 0, -1);
    step("idle_hold",   0, 0, 0, 0, 0, 1,   0,    0, 0, 0,  0);
    step("spur_idle",   0, 1, 1, 1, 1, 1,   0,    0, 0, 0,  0);
    step("start",       1, 0, 0, 0, 0, 1,   1,    0, 0, 0,  0);
    step("spur_p1pl",   0, 0, 1, 1, 1, 1,   1,    0, 0, 0,  0);
    step("p1_ready",    0, 1, 0, 0, 0, 1,   2,    0, 0, 0,  0);
    step("spur_p2pl",   1, 1, 0, 1, 1, 1,   2,    0, 0, 0,  0);
    step("p2_ready",    0, 0, 1, 0, 0, 1,   3,    0, 0, 0,  0);
    step("p1_hit1",     0, 0, 0, 1, 1, 1,   4,    1, 0, 0,  0);
    step("p2_miss",     0, 0, 0, 1, 0, 1,   3,    1, 0, 0,  0);
    step("p1_hit2",     0, 0, 0, 1, 1, 1,   4,    2, 0, 0,  0);
    step("p2_hit1",     0, 0, 0, 1, 1, 1,   3,    2, 1, 0,  0);
    // P1 idles: entry cycle plus six more quiet cycles, start ignored.
    step("p1_idle_st",  1, 0, 0, 0, 0, 1,   3,    2, 1, 0,  0);
    for (int i = 1; i < 7; i++)
      step($sformatf("p1_idle%0d", i), 0, 0, 0, 0, 0, 1, 3, 2, 1, 0, 0);
    step("p1_forfeit",  0, 0, 0, 0, 0, 1,   4,    2, 1, 0,  1);
    // P2 idles to the last cycle, then fires there: no forfeit pulse.
    for (int i = 0; i < 7; i++)
      step($sformatf("p2_idle%0d", i), 0, 0, 0, 0, 0, 1, 4, 2, 1, 0, 0);
    step("p2_lastfire", 0, 0, 0, 1, 1, 1,   3,    2, 2, 0,  0);
    step("p1_win",      0, 0, 0, 1, 1, 1,   5,    3, 2, 1,  0);
    step("spur_win",    0, 1, 1, 1, 1, 1,   5,    3, 2, 1,  0);
    step("win_hold",    0, 0, 0, 0, 0, 1,   5,    3, 2, 1,  0);
    step("restart",     1, 0, 0, 0, 0, 1,   1,    0, 0, 0,  0);
    step("g2_p1r",      0, 1, 0, 0, 0, 1,   2,    0, 0, 0,  0);
    step("g2_p2r",      0, 0, 1, 0, 0, 1,   3,    0, 0, 0,  0);
    step("g2_p1m1",     0, 0, 0, 1, 0, 1,   4,    0, 0, 0,  0);
    step("g2_p2h1",     0, 0, 0, 1, 1, 1,   3,    0, 1, 0,  0);
    step("g2_p1m2",     0, 0, 0, 1, 0, 1,   4,    0, 1, 0,  0);
    step("g2_p2h2",     0, 0, 0, 1, 1, 1,   3,    0, 2, 0,  0);
    step("g2_p1m3",     0, 0, 0, 1, 0, 1,   4,    0, 2, 0,  0);
    // Reset mid-turn overrides a would-be winning shot.
    step("midrst",      0, 0, 0, 1, 1, 0,   0,    0, 0, 0,  0);
    step("post_rst",    0, 0, 0, 1, 1, 1,   0,    0, 0, 0,  0);
    step("g3_start",    1, 0, 0, 0, 0, 1,   1,    0, 0, 0,  0);
    step("g3_p1r",      0, 1, 0, 0, 0, 1,   2,    0, 0, 0,  0);
    step("g3_p2r",      0, 0, 1, 0, 0, 1,   3,    0, 0, 0,  0);
    step("g3_p1m1",     0, 0, 0, 1, 0, 1,   4,    0, 0, 0,  0);
    step("g3_p2h1",     0, 0, 0, 1, 1, 1,   3,    0, 1, 0,  0);
    step("g3_p1m2",     0, 0, 0, 1, 0, 1,   4,    0, 1, 0,  0);
    step("g3_p2h2",     0, 0, 0, 1, 1, 1,   3,    0, 2, 0,  0);
    step("g3_p1m3",     0, 0, 0, 1, 0, 1,   4,    0, 2, 0,  0);
    step("p2_win",      0, 0, 0, 1, 1, 1,   6,    0, 3, 1,  0);
    step("spur_p2win",  0, 0, 0, 1, 1, 1,   6,    0, 3, 1,  0);
    step("restart2",    1, 0, 0, 0, 0, 1,   1,    0, 0, 0,  0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
